// File: rtl/keypad_key_capture.sv
// Keypad key capture: synchronizes the scanner result, debounces press and release,
// freezes row scanning while a key is down and keeps a two-digit key history.
module keypad_key_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned RELEASE_CYCLES  = 120000,
  parameter int unsigned CNT_W           = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pressed,
  input  logic [3:0] key,
  output logic       scan_hold,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RelLast = CNT_W'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDebounce, StHeld, StRelease} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             accept;

  logic       pressed_meta, pressed_s;
  logic [3:0] key_meta, key_s;

  logic       key_valid_q;
  logic [3:0] key_code_q, digit_new_q, digit_old_q;

  // Two-flop synchronizer; the scanner runs asynchronously to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pressed_meta <= 1'b0;
      pressed_s    <= 1'b0;
      key_meta     <= 4'h0;
      key_s        <= 4'h0;
    end else begin
      pressed_meta <= pressed;
      pressed_s    <= pressed_meta;
      key_meta     <= key;
      key_s        <= key_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cand_q      <= 4'h0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= accept;
      if (accept) begin
        key_code_q  <= cand_q;
        digit_new_q <= cand_q;
        digit_old_q <= digit_new_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pressed_s) begin
          cand_d  = key_s;
          cnt_d   = '0;
          state_d = StDebounce;
        end
      end
      StDebounce: begin
        if (!pressed_s) begin
          state_d = StIdle;
        end else if (key_s != cand_q) begin
          cand_d = key_s;
          cnt_d  = '0;
        end else if (cnt_q == DebLast) begin
          accept  = 1'b1;
          state_d = StHeld;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        // Key changes are ignored here: a second key while one is held is never reported.
        if (!pressed_s) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (pressed_s) begin
          state_d = StHeld;
        end else if (cnt_q == RelLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign scan_hold = (state_q != StIdle);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;

endmodule
